uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter UART_BPS, default 115200, serial baud rate.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-003 SHALL derive BAUD_CNT_MAX = CLK_FREQ/UART_BPS (434 at defaults) and HALF_CNT = BAUD_CNT_MAX/2 (217).
REQ-004 SHALL have port sys_clk  input  1  system clock; one clock domain for the whole block.
REQ-005 SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-007 SHALL have port po_data  output  8  last correctly framed byte.
REQ-008 SHALL have port po_flag  output  1  one-cycle strobe marking po_data as new.
REQ-009 SHALL have port frame_err  output  1  one-cycle strobe on a bad stop bit.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass rx through two synchronizer flops (rx_s1, rx_s2), then one history flop (rx_s3); logic uses rx_s2 only.
REQ-012 SHALL detect start as rx_s2==0 && rx_s3==1 while in IDLE; a low level without a falling edge SHALL NOT start a frame.
REQ-013 SHALL implement states IDLE, START, DATA, STOP; encoding is free.
REQ-014 SHALL, in IDLE on start detect, go to START with baud_cnt=0 and bit_cnt=0.
REQ-015 SHALL run baud_cnt 0..BAUD_CNT_MAX-1 with wrap to 0 outside IDLE, and hold it at 0 in IDLE.
REQ-016 SHALL take a sample strobe when baud_cnt==HALF_CNT-1, i.e. mid-bit.
REQ-017 SHALL, in START at the sample strobe: rx_s2==0 -> DATA; rx_s2==1 -> IDLE with no output pulse (glitch reject).
REQ-018 SHALL, in DATA at each sample strobe, shift rx_s2 into the MSB of an 8-bit shift register (LSB-first line order) and increment bit_cnt.
REQ-019 SHALL leave DATA for STOP at the strobe that captures the 8th bit (bit_cnt 7 -> 8).
REQ-020 SHALL, in STOP at the sample strobe, go to IDLE, so the FSM is ready for a new start from mid-stop-bit onward.
REQ-021 SHALL, on stop sample ==1, load po_data from the shift register and assert po_flag for exactly one cycle on the next edge; po_data updates only then.
REQ-022 SHALL, on stop sample ==0, assert frame_err for one cycle, with po_flag low and po_data unchanged.
REQ-023 SHALL ignore rx in the cycle of the stop strobe; a falling edge on the following cycles in IDLE starts the next frame (back-to-back frames supported).
REQ-024 SHALL never assert po_flag and frame_err in the same cycle.
REQ-025 SHALL size baud_cnt to hold BAUD_CNT_MAX-1 (at least 13 bits) and bit_cnt at 4 bits.
REQ-026 SHALL set busy combinationally or registered as (state != IDLE), with at most one cycle of lag.

Reset
REQ-027 SHALL, on sys_rst_n low, force at once: state=IDLE; baud_cnt=0; bit_cnt=0; shift register=0; po_data=8'h00; po_flag=0; frame_err=0; rx_s1/rx_s2/rx_s3=1.
REQ-028 SHALL, on reset mid-frame, drop the partial byte with no po_flag or frame_err; after release it needs a fresh falling edge.

Verification
REQ-029 SHALL check: defaults, frame 0x55 at 434 clk/bit -> po_flag pulses once, po_data=8'h55, frame_err=0, busy low after the stop sample.
REQ-030 SHALL check: frame 0xA3 then 0x0F back-to-back, stop bit 1 bit long -> two po_flag pulses, po_data 8'hA3 then 8'h0F.
REQ-031 SHALL check: rx low pulse of 100 clk, then high -> FSM back to IDLE at the START strobe, no po_flag/frame_err, po_data unchanged.
REQ-032 SHALL check: frame 0x3C with stop bit driven 0 -> frame_err pulses once, po_flag stays 0, po_data keeps its prior value.
REQ-033 SHALL check: sys_rst_n low during data bit 4 of 0xFF, released, then frame 0x81 -> no output for the aborted frame, then po_data=8'h81 with one po_flag.
REQ-034 SHALL check: sampling margin, frame 0x96 sent at bit period 434±4% clk -> po_data=8'h96 with no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB-first, mid-bit sampling via a baud counter.
// Ports: sys_clk, sys_rst_n (async, active-low), rx (serial in),
//        po_data (last good byte), po_flag (new-byte strobe),
//        frame_err (bad stop-bit strobe), busy (FSM not idle).
module uart_rx #(
    parameter int UART_BPS = 115200,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam int CNT_RAW      = $clog2(BAUD_CNT_MAX);
    localparam int CNT_W        = (CNT_RAW > 13) ? CNT_RAW : 13;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(HALF_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rx_s1;
    logic               r_rx_s2;
    logic               r_rx_s3;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_po_data;
    logic               r_po_flag;
    logic               r_frame_err;
    logic               w_start;
    logic               w_sample;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // Only a high-to-low transition starts a frame, never a held low.
    assign w_start  = (r_state == IDLE) && !r_rx_s2 && r_rx_s3;
    assign w_sample = (r_baud_cnt == SAMPLE_AT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_state_nxt = START;
            end
            START: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (w_sample) w_state_nxt = r_rx_s2 ? IDLE : DATA;
            end
            DATA: begin
                if (w_sample && (r_bit_cnt == 4'd7)) w_state_nxt = STOP;
            end
            STOP: begin
                // Return at mid-stop so a back-to-back start edge is caught.
                if (w_sample) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt  <= '0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_po_data   <= 8'h00;
            r_po_flag   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_po_flag   <= 1'b0;
            r_frame_err <= 1'b0;

            if ((r_state == IDLE) || (w_state_nxt == IDLE)) begin
                r_baud_cnt <= '0;
            end else if (r_baud_cnt == CNT_LAST) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if (w_start) begin
                r_bit_cnt <= 4'd0;
            end else if ((r_state == DATA) && w_sample) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            // Line is LSB-first, so shift in at the MSB.
            if ((r_state == DATA) && w_sample) begin
                r_shift <= {r_rx_s2, r_shift[7:1]};
            end

            if ((r_state == STOP) && w_sample) begin
                if (r_rx_s2) begin
                    r_po_data <= r_shift;
                    r_po_flag <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign po_data   = r_po_data;
    assign po_flag   = r_po_flag;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule
